// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared encodings for the RV32M divide unit: decode constants,
//               divide operation codes and divider state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    // Decode fields that route an instruction to the divider
    localparam logic [6:0] c_opcode_rtype   = 7'b0110011;
    localparam logic [6:0] c_funct7_muldiv  = 7'b0000001;

    // func3[1:0] of the divide group
    localparam logic [1:0] c_div_op_div     = 2'b00;
    localparam logic [1:0] c_div_op_divu    = 2'b01;
    localparam logic [1:0] c_div_op_rem     = 2'b10;
    localparam logic [1:0] c_div_op_remu    = 2'b11;

    // Divider state encodings
    localparam int         c_state_w        = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_calc = 2'd1;
    localparam logic [c_state_w-1:0] c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//               One quotient bit per cycle on magnitudes, sign fix-up on the
//               final cycle, single-cycle fast path for divide-by-zero and
//               signed overflow. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                c_cnt_w    = $clog2(XLEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(XLEN);
    localparam logic [XLEN-1:0]   c_all_ones = '1;
    localparam logic [XLEN-1:0]   c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [XLEN-1:0]      r_dividend;   // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]      r_divisor;
    logic [XLEN-1:0]      r_rem;        // kept remainder is always below the divisor
    logic                 r_is_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_busy;
    logic                 r_done;
    logic [XLEN-1:0]      r_result;

    logic                 w_signed;
    logic                 w_rs1_neg;
    logic                 w_rs2_neg;
    logic [XLEN-1:0]      w_abs1;
    logic [XLEN-1:0]      w_abs2;
    logic                 w_div0;
    logic                 w_ovf;
    logic [XLEN-1:0]      w_fast_result;
    logic [XLEN:0]        w_shifted;
    logic [XLEN:0]        w_trial;
    logic                 w_qbit;
    logic [XLEN-1:0]      w_rem_next;
    logic [XLEN-1:0]      w_quot_fix;
    logic [XLEN-1:0]      w_rem_fix;
    logic [XLEN-1:0]      w_final;

    // Operand preparation: magnitudes, signs and fast-path detection
    always_comb begin
        w_signed      = ~op[0];
        w_rs1_neg     = w_signed & rs1[XLEN-1];
        w_rs2_neg     = w_signed & rs2[XLEN-1];
        w_abs1        = w_rs1_neg ? -rs1 : rs1;
        w_abs2        = w_rs2_neg ? -rs2 : rs2;
        w_div0        = (rs2 == '0);
        w_ovf         = w_signed & (rs1 == c_int_min) & (rs2 == c_all_ones);
        w_fast_result = '0;
        if (w_div0) begin
            w_fast_result = op[1] ? rs1 : c_all_ones;
        end else if (w_ovf) begin
            w_fast_result = op[1] ? '0 : c_int_min;
        end
    end

    // One restoring step plus the sign fix-up applied when iteration ends
    always_comb begin
        w_shifted  = {r_rem, r_dividend[XLEN-1]};
        w_trial    = w_shifted - {1'b0, r_divisor};
        w_qbit     = ~w_trial[XLEN];
        w_rem_next = w_qbit ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
        w_quot_fix = r_neg_q ? -r_dividend : r_dividend;
        w_rem_fix  = r_neg_r ? -r_rem : r_rem;
        w_final    = r_is_rem ? w_rem_fix : w_quot_fix;
    end

    // Control FSM with datapath registers; reset beats flush, flush beats start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else if (flush) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= c_st_idle;
                    if (start) begin
                        r_is_rem   <= op[1];
                        r_neg_q    <= w_rs1_neg ^ w_rs2_neg;
                        r_neg_r    <= w_rs1_neg;
                        r_dividend <= w_abs1;
                        r_divisor  <= w_abs2;
                        r_rem      <= '0;
                        r_count    <= '0;
                        if (w_div0 || w_ovf) begin
                            r_state  <= c_st_done;
                            r_done   <= 1'b1;
                            r_result <= w_fast_result;
                        end else begin
                            r_state <= c_st_calc;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_st_calc: begin
                    if (r_count == c_last_cnt) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_st_done;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= {r_dividend[XLEN-2:0], w_qbit};
                        r_count    <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: directed RV32M cases,
//               randomized operations against an arithmetic reference,
//               flush/reset abort, ignored start and back-to-back issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int XLEN      = 32;
    localparam int c_calc_lat = XLEN + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'h0) return mop[1] ? a : 32'hFFFF_FFFF;
        if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mop[1] ? 32'h0 : 32'h8000_0000;
        case (mop)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit model_fast(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded)
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: busy=%0b done=%0b result=%h, required 0 0 0", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [10];
        logic [31:0] t_a  [10];
        logic [31:0] t_b  [10];
        logic [31:0] t_e  [10];
        bit          t_f  [10];
        int lat;
        int bc;
        t_op = '{c_div_op_div, c_div_op_rem, c_div_op_div, c_div_op_rem, c_div_op_divu,
                 c_div_op_divu, c_div_op_remu, c_div_op_div, c_div_op_rem, c_div_op_divu};
        t_a  = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
        t_b  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd2,
                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        t_e  = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'd3};
        t_f  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat, bc);
            checks++;
            if (result !== t_e[i]) begin
                errors++;
                $display("FAIL directed[%0d] result: got %h, required %h", i, result, t_e[i]);
            end
            checks++;
            if (lat != (t_f[i] ? 0 : c_calc_lat)) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d, required %0d", i, lat, t_f[i] ? 0 : c_calc_lat);
            end
            checks++;
            if (bc != (t_f[i] ? 0 : c_calc_lat)) begin
                errors++;
                $display("FAIL directed[%0d] busy cycles: got %0d, required %0d", i, bc, t_f[i] ? 0 : c_calc_lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || result !== t_e[i]) begin
                errors++;
                $display("FAIL directed[%0d] pulse/hold: done=%0b result=%h, required 0 %h", i, done, result, t_e[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int lat;
        int bc;
        int want_lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = model(o, a, b);
            want_lat = model_fast(o, a, b) ? 0 : c_calc_lat;
            issue(o, a, b);
            wait_done(lat, bc);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d %h/%h result: got %h, required %h", i, o, a, b, result, exp);
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL random[%0d] latency: got %0d, required %0d", i, lat, want_lat);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int bc;
        issue(c_div_op_divu, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1 op = c_div_op_remu; rs1 = 32'd77; rs2 = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (result !== 32'd100 || lat != c_calc_lat - 6) begin
            errors++;
            $display("FAIL start_in_calc: result=%h lat=%0d, required %h %0d", result, lat, 32'd100, c_calc_lat - 6);
        end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        bit          seen;
        int lat;
        int bc;
        held = result;
        issue(c_div_op_divu, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== held) begin
            errors++;
            $display("FAIL flush: busy=%0b done=%0b result=%h, required 0 0 %h", busy, done, result, held);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush no-done: done pulsed after flush, required none");
        end
        issue(c_div_op_divu, 32'd9, 32'd3);
        wait_done(lat, bc);
        checks++;
        if (result !== 32'd3 || lat != c_calc_lat) begin
            errors++;
            $display("FAIL after-flush: result=%h lat=%0d, required 3 %0d", result, lat, c_calc_lat);
        end
        issue(c_div_op_divu, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst-abort: busy=%0b done=%0b result=%h, required 0 0 0", busy, done, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        issue(c_div_op_divu, 32'd17, 32'd5);
        wait_done(lat, bc);
        checks++;
        if (done !== 1'b1 || result !== 32'd3) begin
            errors++;
            $display("FAIL b2b first: done=%0b result=%h, required 1 3", done, result);
        end
        op = c_div_op_remu; rs1 = 32'd17; rs2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: done=%0b busy=%0b, required 0 1", done, busy);
        end
        wait_done(lat, bc);
        checks++;
        if (result !== 32'd2 || lat != c_calc_lat) begin
            errors++;
            $display("FAIL b2b second: result=%h lat=%0d, required 2 %0d", result, lat, c_calc_lat);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
